kbd_ascii_fifo: RTL and testbench

KBD_ASCII_FIFO -- requirements
Module: kbd_ascii_fifo

---
 rtl/kbd_pkg.sv | 43 ++++
 rtl/kbd_scan2ascii.sv | 108 ++++++++++
 rtl/kbd_ascii_fifo.sv | 168 ++++++++++++++++
 tb/tb_kbd_ascii_fifo.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared scan-code constants, ASCII control codes and the prefix-decoder state type
// for the PS/2 keyboard-to-ASCII FIFO. The KBD_EXT_KEYS_EN macro enables arrow keys.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] SC_CAPS     = 8'h58;
    localparam logic [7:0] SC_ACK      = 8'hFA;
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_ECHO     = 8'hEE;
    localparam logic [7:0] SC_RESEND   = 8'hFE;

    localparam logic [7:0] SC_EXT_UP    = 8'h75;
    localparam logic [7:0] SC_EXT_DOWN  = 8'h72;
    localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
    localparam logic [7:0] SC_EXT_RIGHT = 8'h74;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_TAB   = 8'h09;
    localparam logic [7:0] ASC_ESC   = 8'h1B;
    localparam logic [7:0] ASC_UP    = 8'h11;
    localparam logic [7:0] ASC_DOWN  = 8'h12;
    localparam logic [7:0] ASC_LEFT  = 8'h13;
    localparam logic [7:0] ASC_RIGHT = 8'h14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } kbd_state_t;

    // Keyboard housekeeping replies that must never reach the character path.
    function automatic logic is_discard(input logic [7:0] code);
        return (code == SC_ACK) || (code == SC_BAT_OK) ||
               (code == SC_ECHO) || (code == SC_RESEND);
    endfunction

endpackage

// File: rtl/kbd_scan2ascii.sv
// Combinational set-2 scan code to US-layout ASCII lookup.
// Extended (0xE0-prefixed) codes map to arrow controls only with KBD_EXT_KEYS_EN.
module kbd_scan2ascii
    import kbd_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii,
    output logic       valid
);

    logic [7:0] base;
    logic [7:0] shifted;
    logic       hit;
    logic       letter;

    always_comb begin
        base    = 8'h00;
        shifted = 8'h00;
        hit     = 1'b1;
        case (code)
            8'h1C: base = "a";
            8'h32: base = "b";
            8'h21: base = "c";
            8'h23: base = "d";
            8'h24: base = "e";
            8'h2B: base = "f";
            8'h34: base = "g";
            8'h33: base = "h";
            8'h43: base = "i";
            8'h3B: base = "j";
            8'h42: base = "k";
            8'h4B: base = "l";
            8'h3A: base = "m";
            8'h31: base = "n";
            8'h44: base = "o";
            8'h4D: base = "p";
            8'h15: base = "q";
            8'h2D: base = "r";
            8'h1B: base = "s";
            8'h2C: base = "t";
            8'h3C: base = "u";
            8'h2A: base = "v";
            8'h1D: base = "w";
            8'h22: base = "x";
            8'h35: base = "y";
            8'h1A: base = "z";
            8'h16: begin base = "1";  shifted = "!";  end
            8'h1E: begin base = "2";  shifted = "@";  end
            8'h26: begin base = "3";  shifted = "#";  end
            8'h25: begin base = "4";  shifted = "$";  end
            8'h2E: begin base = "5";  shifted = "%";  end
            8'h36: begin base = "6";  shifted = "^";  end
            8'h3D: begin base = "7";  shifted = "&";  end
            8'h3E: begin base = "8";  shifted = "*";  end
            8'h46: begin base = "9";  shifted = "(";  end
            8'h45: begin base = "0";  shifted = ")";  end
            8'h0E: begin base = 8'h60; shifted = "~";  end
            8'h4E: begin base = "-";  shifted = "_";  end
            8'h55: begin base = "=";  shifted = "+";  end
            8'h54: begin base = "[";  shifted = "{";  end
            8'h5B: begin base = "]";  shifted = "}";  end
            8'h5D: begin base = 8'h5C; shifted = "|";  end
            8'h4C: begin base = ";";  shifted = ":";  end
            8'h52: begin base = "'";  shifted = 8'h22; end
            8'h41: begin base = ",";  shifted = "<";  end
            8'h49: begin base = ".";  shifted = ">";  end
            8'h4A: begin base = "/";  shifted = "?";  end
            8'h29: begin base = ASC_SPACE; shifted = ASC_SPACE; end
            8'h5A: begin base = ASC_CR;    shifted = ASC_CR;    end
            8'h66: begin base = ASC_BS;    shifted = ASC_BS;    end
            8'h0D: begin base = ASC_TAB;   shifted = ASC_TAB;   end
            8'h76: begin base = ASC_ESC;   shifted = ASC_ESC;   end
            default: hit = 1'b0;
        endcase
    end

    // Letters follow shift XOR caps; everything else follows shift alone.
    assign letter = (base >= 8'h61) && (base <= 8'h7A);

    always_comb begin
        ascii = 8'h00;
        valid = 1'b0;
        if (ext) begin
`ifdef KBD_EXT_KEYS_EN
            valid = 1'b1;
            case (code)
                SC_EXT_UP:    ascii = ASC_UP;
                SC_EXT_DOWN:  ascii = ASC_DOWN;
                SC_EXT_LEFT:  ascii = ASC_LEFT;
                SC_EXT_RIGHT: ascii = ASC_RIGHT;
                default:      valid = 1'b0;
            endcase
`else
            valid = 1'b0;
`endif
        end else begin
            valid = hit;
            if (letter)
                ascii = (shift ^ caps) ? (base - 8'h20) : base;
            else
                ascii = shift ? shifted : base;
        end
    end

endmodule

// File: rtl/kbd_ascii_fifo.sv
// PS/2 scan-code capture, prefix/modifier decoder and first-word-fall-through ASCII FIFO.
// Define KBD_EXT_KEYS_EN to turn 0xE0-prefixed arrow keys into ASCII 0x11..0x14.
module kbd_ascii_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk50M,
    input  logic                       rst,
    input  logic                       kbd_int,
    input  logic [7:0]                 kbd_data,
    output logic                       kbd_int_ack,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic       capture;
    logic       ack_reg;
    logic       seen_reg;
    logic       byte_vld_reg;
    logic [7:0] byte_reg;

    // seen_reg blocks a second capture while the same kbd_int assertion is still held.
    assign capture = kbd_int && !ack_reg && !seen_reg;

    always_ff @(posedge clk50M) begin
        if (rst) begin
            ack_reg      <= 1'b0;
            seen_reg     <= 1'b0;
            byte_vld_reg <= 1'b0;
            byte_reg     <= 8'h00;
        end else begin
            ack_reg      <= capture;
            byte_vld_reg <= capture;
            seen_reg     <= kbd_int && (seen_reg || capture);
            if (capture)
                byte_reg <= kbd_data;
        end
    end

    assign kbd_int_ack = ack_reg;

    kbd_state_t state_reg;
    logic       shift_l_reg;
    logic       shift_r_reg;
    logic       caps_reg;
    logic [7:0] map_ascii;
    logic       map_valid;
    logic       push_req;

    kbd_scan2ascii u_map (
        .code  (byte_reg),
        .ext   (state_reg == ST_EXT),
        .shift (shift_l_reg | shift_r_reg),
        .caps  (caps_reg),
        .ascii (map_ascii),
        .valid (map_valid)
    );

    // Only plain makes and EXT makes produce characters; break states never do.
    assign push_req = byte_vld_reg && map_valid &&
                      (((state_reg == ST_IDLE) && !is_discard(byte_reg)) ||
                       (state_reg == ST_EXT));

    always_ff @(posedge clk50M) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            shift_l_reg <= 1'b0;
            shift_r_reg <= 1'b0;
            caps_reg    <= 1'b0;
        end else if (byte_vld_reg) begin
            case (state_reg)
                ST_IDLE: begin
                    if (byte_reg == SC_BREAK)
                        state_reg <= ST_BRK;
                    else if (byte_reg == SC_EXT)
                        state_reg <= ST_EXT;
                    else begin
                        state_reg <= ST_IDLE;
                        if (byte_reg == SC_LSHIFT)
                            shift_l_reg <= 1'b1;
                        if (byte_reg == SC_RSHIFT)
                            shift_r_reg <= 1'b1;
                        if (byte_reg == SC_CAPS)
                            caps_reg <= !caps_reg;
                    end
                end
                ST_BRK: begin
                    if (byte_reg == SC_LSHIFT)
                        shift_l_reg <= 1'b0;
                    if (byte_reg == SC_RSHIFT)
                        shift_r_reg <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                ST_EXT: begin
                    state_reg <= (byte_reg == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          empty_reg;
    logic          overflow_reg;
    logic [7:0]    rd_data_reg;
    logic          full;
    logic          pop_ok;
    logic          wr_ok;
    logic          ovf_evt;

    assign full       = (count_reg == CW'(DEPTH));
    assign pop_ok     = rd_en && !empty_reg;
    assign wr_ok      = push_req && (!full || pop_ok);
    assign ovf_evt    = push_req && full && !pop_ok;
    assign rd_next    = rd_ptr_reg + AW'(1);
    assign count_next = count_reg + CW'(wr_ok) - CW'(pop_ok);

    always_ff @(posedge clk50M) begin
        if (wr_ok && !rst)
            mem[wr_ptr_reg] <= map_ascii;
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            rd_data_reg  <= 8'h00;
        end else begin
            if (wr_ok)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)
                rd_ptr_reg <= rd_next;
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            if (ovf_evt)
                overflow_reg <= 1'b1;
            else if (clr_ovf)
                overflow_reg <= 1'b0;
            // Head register: bypass the incoming character when it becomes the new head.
            if (wr_ok && (empty_reg || (pop_ok && count_reg == CW'(1))))
                rd_data_reg <= map_ascii;
            else if (pop_ok && count_reg > CW'(1))
                rd_data_reg <= mem[rd_next];
        end
    end

    assign rd_data  = rd_data_reg;
    assign empty    = empty_reg;
    assign count    = count_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_kbd_ascii_fifo.sv
// Directed self-checking bench for kbd_ascii_fifo: decoder, modifiers, FIFO limits, resets.
module tb_kbd_ascii_fifo;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk50M = 1'b0;
    logic          rst = 1'b1;
    logic          kbd_int = 1'b0;
    logic [7:0]    kbd_data = 8'h00;
    logic          kbd_int_ack;
    logic          rd_en = 1'b0;
    logic [7:0]    rd_data;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          clr_ovf = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk50M = ~clk50M;

    kbd_ascii_fifo #(.DEPTH(DEPTH)) dut (
        .clk50M      (clk50M),
        .rst         (rst),
        .kbd_int     (kbd_int),
        .kbd_data    (kbd_data),
        .kbd_int_ack (kbd_int_ack),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    // Upstream stub: hold kbd_int until the ack is seen, then leave one cycle for decode.
    task automatic send_byte(input logic [7:0] b);
        bit acked;
        acked = 1'b0;
        @(negedge clk50M);
        kbd_int  = 1'b1;
        kbd_data = b;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk50M); #1;
            if (kbd_int_ack === 1'b1) acked = 1'b1;
        end
        kbd_int = 1'b0;
        n_checks++;
        if (!acked) begin
            n_fail++;
            $display("FAIL ack_timeout: byte %h ack=0 required ack=1", b);
        end
        @(posedge clk50M); #1;
    endtask

    task automatic pop();
        @(negedge clk50M);
        rd_en = 1'b1;
        @(posedge clk50M); #1;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        kbd_int  = 1'b1;
        kbd_data = 8'h1C;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk50M); #1;
            n_checks++;
            if (kbd_int_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_ack: ack=%b required 0", kbd_int_ack);
            end
        end
        kbd_int = 1'b0;
        @(negedge clk50M);
        rst = 1'b0;
        @(posedge clk50M); #1;
        n_checks++;
        if (empty !== 1'b1 || count !== '0 || overflow !== 1'b0 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: empty=%b count=%0d ovf=%b rd_data=%h required 1 0 0 00",
                     empty, count, overflow, rd_data);
        end
    endtask

    task automatic test_make_break();
        send_byte(8'h1C);
        n_checks++;
        if (empty !== 1'b0 || count !== CW'(1) || rd_data !== 8'h61) begin
            n_fail++;
            $display("FAIL make_push: empty=%b count=%0d rd_data=%h required 0 1 61",
                     empty, count, rd_data);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        n_checks++;
        if (count !== CW'(1) || rd_data !== 8'h61) begin
            n_fail++;
            $display("FAIL break_no_push: count=%0d rd_data=%h required 1 61", count, rd_data);
        end
        pop();
        n_checks++;
        if (empty !== 1'b1 || count !== '0) begin
            n_fail++;
            $display("FAIL pop_to_empty: empty=%b count=%0d required 1 0", empty, count);
        end
    endtask

    task automatic test_shift();
        send_byte(8'h12);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h12);
        send_byte(8'h1C);
        n_checks++;
        if (count !== CW'(2) || rd_data !== 8'h41) begin
            n_fail++;
            $display("FAIL shift_upper: count=%0d rd_data=%h required 2 41", count, rd_data);
        end
        pop();
        n_checks++;
        if (rd_data !== 8'h61 || count !== CW'(1)) begin
            n_fail++;
            $display("FAIL shift_released: rd_data=%h count=%0d required 61 1", rd_data, count);
        end
        pop();
    endtask

    task automatic test_caps_and_maps();
        logic [7:0] exp_q [5];
        exp_q = '{8'h41, 8'h61, 8'h31, 8'h21, 8'h20};
        send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
        send_byte(8'h1C);                                   // caps -> 'A'
        send_byte(8'h12); send_byte(8'h1C);                 // caps^shift -> 'a'
        send_byte(8'hF0); send_byte(8'h12);
        send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
        send_byte(8'h16);                                   // '1'
        send_byte(8'h12); send_byte(8'h16);                 // '!'
        send_byte(8'hF0); send_byte(8'h12);
        send_byte(8'h29);                                   // space
        send_byte(8'hFA);
        send_byte(8'h05);
        n_checks++;
        if (count !== CW'(5)) begin
            n_fail++;
            $display("FAIL caps_count: count=%0d required 5", count);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rd_data !== exp_q[i]) begin
                n_fail++;
                $display("FAIL caps_seq[%0d]: rd_data=%h required %h", i, rd_data, exp_q[i]);
            end
            pop();
        end
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL caps_drain: empty=%b required 1", empty);
        end
    endtask

    task automatic test_typematic();
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        n_checks++;
        if (count !== CW'(3)) begin
            n_fail++;
            $display("FAIL typematic_count: count=%0d required 3", count);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rd_data !== 8'h61) begin
                n_fail++;
                $display("FAIL typematic[%0d]: rd_data=%h required 61", i, rd_data);
            end
            pop();
        end
    endtask

    task automatic test_empty_ops();
        pop();
        n_checks++;
        if (empty !== 1'b1 || count !== '0) begin
            n_fail++;
            $display("FAIL pop_on_empty: empty=%b count=%0d required 1 0", empty, count);
        end
        // Pop requested on the same edge as a push into the empty FIFO.
        @(negedge clk50M);
        kbd_int  = 1'b1;
        kbd_data = 8'h1C;
        @(posedge clk50M); #1;
        kbd_int = 1'b0;
        @(negedge clk50M);
        rd_en = 1'b1;
        @(posedge clk50M); #1;
        rd_en = 1'b0;
        n_checks++;
        if (count !== CW'(1) || empty !== 1'b0 || rd_data !== 8'h61) begin
            n_fail++;
            $display("FAIL push_pop_empty: count=%0d empty=%b rd_data=%h required 1 0 61",
                     count, empty, rd_data);
        end
        pop();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h16);
        n_checks++;
        if (count !== CW'(DEPTH) || overflow !== 1'b1 || rd_data !== 8'h31) begin
            n_fail++;
            $display("FAIL overflow_set: count=%0d ovf=%b rd_data=%h required %0d 1 31",
                     count, overflow, rd_data, DEPTH);
        end
        // Overflow event on the same edge as clr_ovf: the event wins.
        @(negedge clk50M);
        kbd_int  = 1'b1;
        kbd_data = 8'h1E;
        @(posedge clk50M); #1;
        kbd_int = 1'b0;
        @(negedge clk50M);
        clr_ovf = 1'b1;
        @(posedge clk50M); #1;
        clr_ovf = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || count !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL ovf_beats_clr: ovf=%b count=%0d required 1 %0d", overflow, count, DEPTH);
        end
        @(negedge clk50M);
        clr_ovf = 1'b1;
        @(posedge clk50M); #1;
        clr_ovf = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ovf: ovf=%b required 0", overflow);
        end
        // Push and pop together while full.
        @(negedge clk50M);
        kbd_int  = 1'b1;
        kbd_data = 8'h1E;
        @(posedge clk50M); #1;
        kbd_int = 1'b0;
        @(negedge clk50M);
        rd_en = 1'b1;
        @(posedge clk50M); #1;
        rd_en = 1'b0;
        n_checks++;
        if (count !== CW'(DEPTH) || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_push_pop: count=%0d ovf=%b required %0d 0", count, overflow, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (rd_data !== ((i == DEPTH - 1) ? 8'h32 : 8'h31)) begin
                n_fail++;
                $display("FAIL drain[%0d]: rd_data=%h required %h", i, rd_data,
                         (i == DEPTH - 1) ? 8'h32 : 8'h31);
            end
            pop();
        end
        n_checks++;
        if (empty !== 1'b1 || count !== '0) begin
            n_fail++;
            $display("FAIL drain_empty: empty=%b count=%0d required 1 0", empty, count);
        end
    endtask

    task automatic test_held_int();
        int n_ack;
        n_ack = 0;
        @(negedge clk50M);
        kbd_int  = 1'b1;
        kbd_data = 8'h1C;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk50M); #1;
            if (kbd_int_ack === 1'b1) n_ack++;
        end
        kbd_int = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk50M); #1;
            if (kbd_int_ack === 1'b1) n_ack++;
        end
        n_checks++;
        if (n_ack != 1 || count !== CW'(1) || rd_data !== 8'h61) begin
            n_fail++;
            $display("FAIL held_int: acks=%0d count=%0d rd_data=%h required 1 1 61",
                     n_ack, count, rd_data);
        end
        pop();
    endtask

    task automatic test_ext();
        send_byte(8'hE0);
        send_byte(8'h75);
`ifdef KBD_EXT_KEYS_EN
        n_checks++;
        if (count !== CW'(1) || rd_data !== 8'h11) begin
            n_fail++;
            $display("FAIL ext_up: count=%0d rd_data=%h required 1 11", count, rd_data);
        end
        pop();
`else
        n_checks++;
        if (count !== '0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL ext_discard: count=%0d empty=%b required 0 1", count, empty);
        end
`endif
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'h1C);
        n_checks++;
        if (count !== CW'(1) || rd_data !== 8'h61) begin
            n_fail++;
            $display("FAIL ext_break: count=%0d rd_data=%h required 1 61", count, rd_data);
        end
        pop();
    endtask

    task automatic test_rst_mid();
        logic [7:0] prefix [2];
        prefix = '{8'hE0, 8'hF0};
        for (int p = 0; p < 2; p++) begin
            send_byte(prefix[p]);
            @(negedge clk50M);
            rst = 1'b1;
            @(posedge clk50M); @(posedge clk50M);
            @(negedge clk50M);
            rst = 1'b0;
            send_byte(8'h1A);
            n_checks++;
            if (count !== CW'(1) || rd_data !== 8'h7A) begin
                n_fail++;
                $display("FAIL rst_mid_%h: count=%0d rd_data=%h required 1 7a",
                         prefix[p], count, rd_data);
            end
            pop();
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_shift();
        test_caps_and_maps();
        test_typematic();
        test_empty_ops();
        test_overflow();
        test_held_int();
        test_ext();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
